// File: rtl/ls163_seq_ctrl.sv
// Sequencer for a 74LS163-style 4-bit counter: loads a latched preset, counts up to a
// latched terminal value for a programmable number of passes, with run/pause/step/abort.
module ls163_seq_ctrl #(
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_start,
   input  logic         i_stop,
   input  logic         i_step,
   input  logic         i_abort,
   input  logic [W-1:0] i_preset,
   input  logic [W-1:0] i_term,
   input  logic [3:0]   i_loops,
   input  logic [W-1:0] i_q,
   output logic         o_ld_n,
   output logic         o_enp,
   output logic         o_ent,
   output logic         o_cnt_clr_n,
   output logic [W-1:0] o_data,
   output logic [3:0]   o_pass_cnt,
   output logic         o_busy,
   output logic         o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_PAUSE,
      S_DONE,
      S_CLEAR
   } state_t;

   typedef enum logic [2:0] {
      C_NONE,
      C_STEP,
      C_START,
      C_STOP,
      C_ABORT
   } cmd_t;

   state_t       r_state;
   state_t       w_next;
   cmd_t         w_cmd;
   logic [W-1:0] r_preset;
   logic [W-1:0] r_term;
   logic [3:0]   r_loops;
   logic [3:0]   r_pass_cnt;
   logic         w_terminal;
   logic         w_last;
   logic         w_advance;
   logic         w_latch;
   logic         w_pass_inc;
   logic         w_ld_n;
   logic         w_en;
   logic         w_clr_n;

   // Only the highest-priority command asserted this cycle is considered.
   always_comb begin
      w_cmd = C_NONE;
      if (i_abort)      w_cmd = C_ABORT;
      else if (i_stop)  w_cmd = C_STOP;
      else if (i_start) w_cmd = C_START;
      else if (i_step)  w_cmd = C_STEP;
   end

   assign w_terminal = (i_q == r_term);
   assign w_last     = (r_loops != 4'd0) && ((r_pass_cnt + 4'd1) == r_loops);

   always_comb begin
      w_next     = r_state;
      w_ld_n     = 1'b1;
      w_en       = 1'b0;
      w_clr_n    = 1'b1;
      w_latch    = 1'b0;
      w_pass_inc = 1'b0;
      w_advance  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_cmd == C_START) begin
               w_latch = 1'b1;
               w_next  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_cmd == C_ABORT) begin
               w_next = S_CLEAR;
            end else begin
               w_ld_n = 1'b0;
               w_next = S_RUN;
            end
         end
         S_RUN: begin
            if (w_cmd == C_ABORT)     w_next = S_CLEAR;
            else if (w_cmd == C_STOP) w_next = S_PAUSE;
            else                      w_advance = 1'b1;
         end
         S_PAUSE: begin
            if (w_cmd == C_ABORT)      w_next = S_CLEAR;
            else if (w_cmd == C_START) w_next = S_RUN;
            else if (w_cmd == C_STEP)  w_advance = 1'b1;
         end
         S_DONE: begin
            if (w_cmd == C_ABORT) begin
               w_next = S_CLEAR;
            end else if (w_cmd == C_START) begin
               w_latch = 1'b1;
               w_next  = S_LOAD;
            end
         end
         S_CLEAR: begin
            w_clr_n = 1'b0;
            w_next  = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase

      // A counting cycle: reload at the terminal value, or stop there on the final pass.
      if (w_advance) begin
         if (w_terminal) begin
            w_pass_inc = 1'b1;
            if (w_last) w_next = S_DONE;
            else        w_ld_n = 1'b0;
         end else begin
            w_en = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_preset   <= '0;
         r_term     <= '0;
         r_loops    <= '0;
         r_pass_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (w_latch) begin
            r_preset   <= i_preset;
            r_term     <= i_term;
            r_loops    <= i_loops;
            r_pass_cnt <= '0;
         end else if (w_pass_inc) begin
            r_pass_cnt <= r_pass_cnt + 4'd1;
         end
      end
   end

   assign o_ld_n      = w_ld_n;
   assign o_enp       = w_en;
   assign o_ent       = w_en;
   assign o_cnt_clr_n = w_clr_n;
   assign o_data      = r_preset;
   assign o_pass_cnt  = r_pass_cnt;
   assign o_busy      = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
   assign o_done      = (r_state == S_DONE);

endmodule

// File: tb/tb_ls163_seq_ctrl.sv
// Bench for ls163_seq_ctrl: a behavioural 74LS163 closes the q loop, and a
// run-level model predicts the counter value, pass count and busy/done flags.
module tb_ls163_seq_ctrl;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       start = 1'b0, stop = 1'b0, step = 1'b0, abort = 1'b0;
   logic [3:0] preset = '0, term = '0, loops = '0;
   logic [3:0] counterQ = '0;
   logic       ldN, enp, ent, clrN, busy, done;
   logic [3:0] data, passCnt;

   int checks = 0;
   int errors = 0;

   typedef enum {M_IDLE, M_LOAD, M_RUN, M_PAUSE, M_DONE, M_CLEAR} mode_t;
   mode_t      mMode = M_IDLE;
   logic [3:0] mQ = '0, mPreset = '0, mTerm = '0, mLoops = '0, mPass = '0;

   ls163_seq_ctrl #(.W(4)) dut (
      .i_clk(clk), .i_rst_n(rstN), .i_start(start), .i_stop(stop), .i_step(step),
      .i_abort(abort), .i_preset(preset), .i_term(term), .i_loops(loops), .i_q(counterQ),
      .o_ld_n(ldN), .o_enp(enp), .o_ent(ent), .o_cnt_clr_n(clrN), .o_data(data),
      .o_pass_cnt(passCnt), .o_busy(busy), .o_done(done)
   );

   always #5 clk = ~clk;

   // External 74LS163: sync clear beats sync load beats count.
   always @(posedge clk) begin
      if (!clrN)          counterQ <= 4'd0;
      else if (!ldN)      counterQ <= data;
      else if (enp && ent) counterQ <= counterQ + 4'd1;
   end

   task automatic modelReset();
      mMode = M_IDLE; mPreset = '0; mTerm = '0; mLoops = '0; mPass = '0;
   endtask

   task automatic modelLatch();
      mPreset = preset; mTerm = term; mLoops = loops; mPass = '0; mMode = M_LOAD;
   endtask

   task automatic modelCount();
      if (mQ == mTerm) begin
         mPass = mPass + 4'd1;
         if (mLoops != 4'd0 && mPass == mLoops) mMode = M_DONE;
         else                                   mQ = mPreset;
      end else begin
         mQ = mQ + 4'd1;
      end
   endtask

   task automatic applyStimulus(input logic a, input logic s, input logic st, input logic sp);
      int cmd;
      abort = a; stop = s; start = st; step = sp;
      cmd = a ? 4 : s ? 3 : st ? 2 : sp ? 1 : 0;
      @(posedge clk);
      case (mMode)
         M_IDLE:  if (cmd == 2) modelLatch();
         M_LOAD:  if (cmd == 4) mMode = M_CLEAR; else begin mQ = mPreset; mMode = M_RUN; end
         M_RUN:   if (cmd == 4) mMode = M_CLEAR; else if (cmd == 3) mMode = M_PAUSE; else modelCount();
         M_PAUSE: if (cmd == 4) mMode = M_CLEAR; else if (cmd == 2) mMode = M_RUN;
                  else if (cmd == 1) modelCount();
         M_DONE:  if (cmd == 4) mMode = M_CLEAR; else if (cmd == 2) modelLatch();
         M_CLEAR: begin mQ = 4'd0; mMode = M_IDLE; end
         default: mMode = M_IDLE;
      endcase
      #1;
      abort = 0; stop = 0; start = 0; step = 0;
   endtask

   task automatic test_reset();
      rstN = 1'b0;
      #12;
      checks++;
      if ({ldN, enp, ent, clrN, data, passCnt, busy, done} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %b expected %b",
                  {ldN, enp, ent, clrN, data, passCnt, busy, done}, 14'b10010000000000);
      end
      @(posedge clk); #1;
      rstN = 1'b1;
      modelReset();
   endtask

   task automatic test_two_passes();
      int expSeq[10] = '{3, 4, 5, 6, 7, 3, 4, 5, 6, 7};
      preset = 4'd3; term = 4'd7; loops = 4'd2;
      applyStimulus(0, 0, 1, 0);
      checks++;
      if (ldN !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("[TB] FAIL load_cycle: got ld_n=%b busy=%b expected ld_n=0 busy=1", ldN, busy);
      end
      preset = 4'd9; term = 4'd12; loops = 4'd5;
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (counterQ !== 4'(expSeq[i]) || ldN !== ((i == 4) ? 1'b0 : 1'b1)) begin
            errors++;
            $display("[TB] FAIL two_pass_seq[%0d]: got q=%0d ld_n=%b expected q=%0d ld_n=%b",
                     i, counterQ, ldN, expSeq[i], (i == 4) ? 1'b0 : 1'b1);
         end
         applyStimulus(0, 0, 0, 0);
      end
      checks++;
      if (done !== 1'b1 || passCnt !== 4'd2 || counterQ !== 4'd7 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL two_pass_end: got done=%b pass=%0d q=%0d busy=%b expected 1 2 7 0", done, passCnt, counterQ, busy);
      end
      applyStimulus(0, 0, 0, 0);
      checks++;
      if (counterQ !== 4'd7 || done !== 1'b1) begin
         errors++; $display("[TB] FAIL two_pass_hold: got q=%0d done=%b expected q=7 done=1", counterQ, done);
      end
   endtask

   task automatic test_wrap();
      int expSeq[4] = '{14, 15, 0, 1};
      preset = 4'd14; term = 4'd1; loops = 4'd1;
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (counterQ !== 4'(expSeq[i])) begin
            errors++; $display("[TB] FAIL wrap_seq[%0d]: got q=%0d expected %0d", i, counterQ, expSeq[i]);
         end
         applyStimulus(0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0);
      checks++;
      if (done !== 1'b1 || passCnt !== 4'd1 || counterQ !== 4'd1) begin
         errors++;
         $display("[TB] FAIL wrap_end: got done=%b pass=%0d q=%0d expected 1 1 1", done, passCnt, counterQ);
      end
   endtask

   task automatic test_pause_step();
      int expStep[3] = '{6, 7, 3};
      int budget = 0;
      preset = 4'd3; term = 4'd7; loops = 4'd0;
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      while (counterQ != 4'd5 && budget < 20) begin
         applyStimulus(0, 0, 0, 0);
         budget++;
      end
      checks++;
      if (counterQ !== 4'd5) begin
         errors++; $display("[TB] FAIL pause_reach5: got q=%0d expected 5 within 20 cycles", counterQ);
      end
      applyStimulus(0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checks++;
      if (counterQ !== 4'd5 || busy !== 1'b1 || enp !== 1'b0) begin
         errors++; $display("[TB] FAIL pause_hold: got q=%0d busy=%b enp=%b expected 5 1 0", counterQ, busy, enp);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 1);
         checks++;
         if (counterQ !== 4'(expStep[i])) begin
            errors++; $display("[TB] FAIL step[%0d]: got q=%0d expected %0d", i, counterQ, expStep[i]);
         end
      end
      checks++;
      if (passCnt !== 4'd1) begin
         errors++; $display("[TB] FAIL step_pass: got pass=%0d expected 1", passCnt);
      end
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      checks++;
      if (counterQ !== 4'd5 || done !== 1'b0) begin
         errors++; $display("[TB] FAIL resume: got q=%0d done=%b expected q=5 done=0", counterQ, done);
      end
   endtask

   task automatic test_abort();
      int budget = 0;
      preset = 4'd2; term = 4'd9; loops = 4'd0;
      applyStimulus(0, 1, 0, 0);
      applyStimulus(1, 0, 0, 0);
      applyStimulus(0, 0, 0, 0);
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      while (counterQ != 4'd6 && budget < 20) begin
         applyStimulus(0, 0, 0, 0);
         budget++;
      end
      applyStimulus(1, 0, 0, 0);
      checks++;
      if (clrN !== 1'b0 || ldN !== 1'b1 || counterQ !== 4'd6) begin
         errors++; $display("[TB] FAIL abort_clear: got clr_n=%b ld_n=%b q=%0d expected 0 1 6", clrN, ldN, counterQ);
      end
      applyStimulus(0, 0, 0, 0);
      checks++;
      if (counterQ !== 4'd0 || clrN !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_idle: got q=%0d clr_n=%b busy=%b done=%b expected 0 1 0 0", counterQ, clrN, busy, done);
      end
   endtask

   task automatic test_equal();
      preset = 4'd9; term = 4'd9; loops = 4'd3;
      applyStimulus(0, 0, 1, 0);
      applyStimulus(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (counterQ !== 4'd9 || ldN !== ((i < 2) ? 1'b0 : 1'b1) || enp !== 1'b0) begin
            errors++; $display("[TB] FAIL equal[%0d]: got q=%0d ld_n=%b enp=%b", i, counterQ, ldN, enp);
         end
         applyStimulus(0, 0, 0, 0);
      end
      checks++;
      if (done !== 1'b1 || passCnt !== 4'd3 || counterQ !== 4'd9) begin
         errors++; $display("[TB] FAIL equal_end: got done=%b pass=%0d q=%0d expected 1 3 9", done, passCnt, counterQ);
      end
   endtask

   task automatic test_async_reset();
      preset = 4'd3; term = 4'd7; loops = 4'd3;
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 0);
      #2 rstN = 1'b0;
      modelReset();
      #1;
      checks++;
      if ({ldN, enp, ent, busy, passCnt, done} !== 9'b100000000) begin
         errors++; $display("[TB] FAIL async_reset: got %b expected 100000000", {ldN, enp, ent, busy, passCnt, done});
      end
      @(posedge clk); #1;
      rstN = 1'b1;
      loops = 4'd1;
      applyStimulus(0, 0, 1, 0);
      for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0);
      checks++;
      if (done !== 1'b1 || passCnt !== 4'd1 || counterQ !== 4'd7) begin
         errors++; $display("[TB] FAIL restart: got done=%b pass=%0d q=%0d expected 1 1 7", done, passCnt, counterQ);
      end
   endtask

   task automatic test_random();
      int r;
      for (int i = 0; i < 400; i++) begin
         preset = 4'($urandom_range(0, 15));
         term   = 4'($urandom_range(0, 15));
         loops  = 4'($urandom_range(0, 3));
         r = $urandom_range(0, 99);
         applyStimulus(r < 2, (r >= 2 && r < 9), (r >= 9 && r < 20), (r >= 20 && r < 40));
         checks++;
         if (counterQ !== mQ || passCnt !== mPass || data !== mPreset
             || busy !== (mMode == M_LOAD || mMode == M_RUN || mMode == M_PAUSE) || done !== (mMode == M_DONE)) begin
            errors++;
            $display("[TB] FAIL random[%0d]: got q=%0d pass=%0d data=%0d busy=%b done=%b expected q=%0d pass=%0d data=%0d mode=%s",
                     i, counterQ, passCnt, data, busy, done, mQ, mPass, mPreset, mMode.name());
         end
         checks++;
         if ((ldN === 1'b0 && clrN === 1'b0) || enp !== ent) begin
            errors++; $display("[TB] FAIL random_ctrl[%0d]: got ld_n=%b clr_n=%b enp=%b ent=%b", i, ldN, clrN, enp, ent);
         end
      end
   endtask

   initial begin
      test_reset();
      test_two_passes();
      test_wrap();
      test_pause_step();
      test_abort();
      test_equal();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
